// File: rtl/pfb_mul_arbiter.sv
// ============================================================================
//  pfb_mul_arbiter
//  Round-robin arbiter that shares one pipelined unsigned multiplier between
//  NUM_REQ requesters, with in-order tagged results and a delivery counter.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module pfb_mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int A_WIDTH = 11,
  parameter int B_WIDTH = 13,
  parameter int P_WIDTH = 23,
  parameter int LATENCY = 2
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0]   req_b,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [$clog2(NUM_REQ)-1:0]   res_id,
  output logic [P_WIDTH-1:0]           res_data,
  output logic                         busy,
  output logic [15:0]                  prod_count
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int FW  = (A_WIDTH + B_WIDTH > P_WIDTH) ? (A_WIDTH + B_WIDTH) : P_WIDTH;

  logic [LATENCY-1:0] vld_q;
  logic [IDW-1:0]     id_q  [LATENCY];
  logic [P_WIDTH-1:0] dat_q [LATENCY];
  logic [IDW-1:0]     last_grant_q, last_grant_d;
  logic [15:0]        prod_count_q, prod_count_d;

  logic               adv, found, xfer;
  logic [IDW-1:0]     win, cand;
  logic [IDW:0]       sum;
  logic [A_WIDTH-1:0] a_sel;
  logic [B_WIDTH-1:0] b_sel;
  logic [FW-1:0]      full;
  logic [P_WIDTH-1:0] prod;

  assign adv = !res_valid || res_ready;

  // Search starts one past the last winner and wraps; first valid wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      sum = {1'b0, last_grant_q} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NUM_REQ)) sum = sum - (IDW+1)'(NUM_REQ);
      cand = sum[IDW-1:0];
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign xfer = found && adv && !ap_rst;

  always_comb begin
    req_ready = '0;
    a_sel     = '0;
    b_sel     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == IDW'(i)) begin
        req_ready[i] = xfer;
        a_sel        = req_a[i*A_WIDTH +: A_WIDTH];
        b_sel        = req_b[i*B_WIDTH +: B_WIDTH];
      end
    end
  end

  // The only multiplier; its operands come from the arbitration mux.
  assign full = FW'(a_sel) * FW'(b_sel);
  assign prod = full[P_WIDTH-1:0];

  assign last_grant_d = xfer ? win : last_grant_q;
  assign prod_count_d = prod_count_q + {15'd0, res_valid && res_ready};

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      vld_q        <= '0;
      last_grant_q <= IDW'(NUM_REQ - 1);
      prod_count_q <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        id_q[k]  <= '0;
        dat_q[k] <= '0;
      end
    end else begin
      if (adv) begin
        vld_q[0] <= xfer;
        id_q[0]  <= win;
        dat_q[0] <= prod;
        for (int k = 1; k < LATENCY; k++) begin
          vld_q[k] <= vld_q[k-1];
          id_q[k]  <= id_q[k-1];
          dat_q[k] <= dat_q[k-1];
        end
      end
      last_grant_q <= last_grant_d;
      prod_count_q <= prod_count_d;
    end
  end

  assign res_valid  = vld_q[LATENCY-1];
  assign res_id     = id_q[LATENCY-1];
  assign res_data   = dat_q[LATENCY-1];
  assign busy       = |vld_q;
  assign prod_count = prod_count_q;

endmodule

`default_nettype wire
